// File: rtl/uart_data_loader_pkg.sv
// -----------------------------------------------------------------------------
// uart_data_loader_pkg
//   Shared definitions for the UART data-memory loader: oversampling default,
//   baud-tick divider computation and the state encodings of the receiver FSM
//   and the loader FSM.
// -----------------------------------------------------------------------------
package uart_data_loader_pkg;

   localparam int OVERSAMPLE_DEF = 16;

   // Rounded clock divider giving one oversample tick per DIV system clocks.
   function automatic int divCalc(input int clkHz, input int baud, input int overSample);
      return (clkHz + (baud * overSample) / 2) / (baud * overSample);
   endfunction

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rxState_t;

   typedef enum logic [1:0] {
      LD_IDLE = 2'd0,
      LD_LOAD = 2'd1,
      LD_DONE = 2'd2
   } ldState_t;

endpackage

// File: rtl/uart_rx_core.sv
// -----------------------------------------------------------------------------
// uart_rx_core
//   8N1 UART receiver, LSB first, with 2-flop input synchronizer, free-running
//   oversample tick generator and a start/data/stop FSM sampling at mid-bit.
// Ports
//   clk           in   system clock
//   rst           in   synchronous active-high reset
//   rxIn          in   asynchronous serial line, idle high
//   byteValid     out  one-cycle pulse, byteData holds a received byte
//   byteData      out  last received byte
//   frameErrPulse out  one-cycle pulse, stop bit sampled low (byte dropped)
// -----------------------------------------------------------------------------
module uart_rx_core
   import uart_data_loader_pkg::*;
#(
   parameter int CLK_HZ     = 100_000_000,
   parameter int BAUD       = 115200,
   parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rxIn,
   output logic       byteValid,
   output logic [7:0] byteData,
   output logic       frameErrPulse
);

   localparam int DIV   = divCalc(CLK_HZ, BAUD, OVERSAMPLE);
   localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int OS_W  = $clog2(OVERSAMPLE);
   localparam logic [OS_W-1:0] MID_TICK  = OS_W'(OVERSAMPLE / 2 - 1);
   localparam logic [OS_W-1:0] LAST_TICK = OS_W'(OVERSAMPLE - 1);

   logic             rxMeta;
   logic             rxSync;
   logic [DIV_W-1:0] divCnt;
   logic             tick;
   rxState_t         rxState;
   logic [OS_W-1:0]  tickCnt;
   logic [2:0]       bitCnt;
   logic [7:0]       shiftReg;

   // Synchronizer resets to idle-high so leaving reset never looks like a start bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         rxMeta <= 1'b1;
         rxSync <= 1'b1;
      end else begin
         rxMeta <= rxIn;
         rxSync <= rxMeta;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         divCnt <= '0;
         tick   <= 1'b0;
      end else if (divCnt == DIV_W'(DIV - 1)) begin
         divCnt <= '0;
         tick   <= 1'b1;
      end else begin
         divCnt <= divCnt + 1'b1;
         tick   <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rxState       <= RX_IDLE;
         tickCnt       <= '0;
         bitCnt        <= '0;
         shiftReg      <= '0;
         byteData      <= '0;
         byteValid     <= 1'b0;
         frameErrPulse <= 1'b0;
      end else begin
         byteValid     <= 1'b0;
         frameErrPulse <= 1'b0;
         case (rxState)
            RX_IDLE: begin
               tickCnt <= '0;
               bitCnt  <= '0;
               if (!rxSync) rxState <= RX_START;
            end
            RX_START: if (tick) begin
               // Re-check the line at mid start bit to reject short glitches.
               if (tickCnt == MID_TICK) begin
                  tickCnt <= '0;
                  rxState <= rxSync ? RX_IDLE : RX_DATA;
               end else begin
                  tickCnt <= tickCnt + 1'b1;
               end
            end
            RX_DATA: if (tick) begin
               if (tickCnt == LAST_TICK) begin
                  tickCnt  <= '0;
                  shiftReg <= {rxSync, shiftReg[7:1]};
                  bitCnt   <= bitCnt + 1'b1;
                  if (bitCnt == 3'd7) rxState <= RX_STOP;
               end else begin
                  tickCnt <= tickCnt + 1'b1;
               end
            end
            RX_STOP: if (tick) begin
               if (tickCnt == LAST_TICK) begin
                  tickCnt <= '0;
                  rxState <= RX_IDLE;
                  if (rxSync) begin
                     byteValid <= 1'b1;
                     byteData  <= shiftReg;
                  end else begin
                     frameErrPulse <= 1'b1;
                  end
               end else begin
                  tickCnt <= tickCnt + 1'b1;
               end
            end
            default: rxState <= RX_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/uart_data_loader.sv
// -----------------------------------------------------------------------------
// uart_data_loader
//   Receives bytes over UART, packs them little-endian into 32-bit words and
//   writes WORD_COUNT words into data memory starting at byte address 0.
// Ports
//   clk         in   system clock
//   rst         in   synchronous active-high reset
//   uart_rx     in   asynchronous serial input, idle high
//   start_load  in   one-cycle pulse arming (or restarting) a load session
//   mem_we      out  one-cycle data-memory write strobe
//   mem_addr    out  byte address = word index * 4
//   mem_wdata   out  assembled word (first byte received in bits 7:0)
//   load_busy   out  session active, CPU clock must be held off
//   load_done   out  all words written; held until next start_load or rst
//   frame_err   out  sticky: a frame error was seen this session
// -----------------------------------------------------------------------------
module uart_data_loader
   import uart_data_loader_pkg::*;
#(
   parameter int CLK_HZ     = 100_000_000,
   parameter int BAUD       = 115200,
   parameter int OVERSAMPLE = OVERSAMPLE_DEF,
   parameter int ADDR_W     = 12,
   parameter int WORD_COUNT = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              uart_rx,
   input  logic              start_load,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              load_busy,
   output logic              load_done,
   output logic              frame_err
);

   localparam int WIDX_W = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;
   localparam logic [WIDX_W-1:0] LAST_WORD = WIDX_W'(WORD_COUNT - 1);

   logic              byteValid;
   logic [7:0]        byteData;
   logic              frameErrPulse;
   ldState_t          ldState;
   logic [1:0]        laneIdx;
   logic [23:0]       laneBuf;
   logic [WIDX_W-1:0] wordIdx;
   logic              finishPending;

   uart_rx_core #(
      .CLK_HZ     (CLK_HZ),
      .BAUD       (BAUD),
      .OVERSAMPLE (OVERSAMPLE)
   ) rxCore (
      .clk           (clk),
      .rst           (rst),
      .rxIn          (uart_rx),
      .byteValid     (byteValid),
      .byteData      (byteData),
      .frameErrPulse (frameErrPulse)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         ldState       <= LD_IDLE;
         laneIdx       <= '0;
         laneBuf       <= '0;
         wordIdx       <= '0;
         finishPending <= 1'b0;
         mem_we        <= 1'b0;
         mem_addr      <= '0;
         mem_wdata     <= '0;
         load_busy     <= 1'b0;
         load_done     <= 1'b0;
         frame_err     <= 1'b0;
      end else begin
         mem_we <= 1'b0;
         // A start pulse always wins: it restarts from any state and drops
         // any byte arriving in the same cycle along with the partial word.
         if (start_load) begin
            ldState       <= LD_LOAD;
            laneIdx       <= '0;
            laneBuf       <= '0;
            wordIdx       <= '0;
            finishPending <= 1'b0;
            load_busy     <= 1'b1;
            load_done     <= 1'b0;
            frame_err     <= 1'b0;
         end else if (ldState == LD_LOAD) begin
            if (frameErrPulse) frame_err <= 1'b1;
            if (finishPending) begin
               // Last word went out in the previous cycle.
               ldState       <= LD_DONE;
               finishPending <= 1'b0;
               load_busy     <= 1'b0;
               load_done     <= 1'b1;
            end else if (byteValid) begin
               if (laneIdx == 2'd3) begin
                  mem_we    <= 1'b1;
                  mem_wdata <= {byteData, laneBuf};
                  mem_addr  <= ADDR_W'({wordIdx, 2'b00});
                  laneIdx   <= '0;
                  if (wordIdx == LAST_WORD) finishPending <= 1'b1;
                  else                      wordIdx       <= wordIdx + 1'b1;
               end else begin
                  case (laneIdx)
                     2'd0:    laneBuf[7:0]   <= byteData;
                     2'd1:    laneBuf[15:8]  <= byteData;
                     default: laneBuf[23:16] <= byteData;
                  endcase
                  laneIdx <= laneIdx + 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_data_loader.sv
// -----------------------------------------------------------------------------
// tb_uart_data_loader
//   Directed bench for uart_data_loader. Uses a fast baud setting
//   (4.8 MHz / 100 kBd / x16 -> divider 3, 48 clocks per bit).
// -----------------------------------------------------------------------------
module tb_uart_data_loader;

   localparam int CLK_HZ  = 4_800_000;
   localparam int BAUD    = 100_000;
   localparam int BIT_CYC = 48;
   localparam int ADDR_W  = 12;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              uart_rx = 1'b1;
   logic              start_load = 1'b0;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              load_busy;
   logic              load_done;
   logic              frame_err;

   int nCmp = 0;
   int nErr = 0;
   int wrCount = 0;
   logic [31:0] wrAddr [$];
   logic [31:0] wrData [$];

   uart_data_loader #(
      .CLK_HZ     (CLK_HZ),
      .BAUD       (BAUD),
      .OVERSAMPLE (16),
      .ADDR_W     (ADDR_W),
      .WORD_COUNT (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .uart_rx    (uart_rx),
      .start_load (start_load),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .load_busy  (load_busy),
      .load_done  (load_done),
      .frame_err  (frame_err)
   );

   always #5 clk = ~clk;

   // Write monitor: every strobe is logged once (mem_we is one cycle wide).
   always @(negedge clk) begin
      if (mem_we) begin
         wrAddr.push_back(32'(mem_addr));
         wrData.push_back(mem_wdata);
         wrCount = wrCount + 1;
      end
   end

   task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nCmp = nCmp + 1;
      if (got !== exp) begin
         nErr = nErr + 1;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // stopOk=0 holds the stop bit low for 2/3 of its length, then releases.
   task automatic sendByte(input logic [7:0] b, input bit stopOk);
      uart_rx = 1'b0;
      idle(BIT_CYC);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         idle(BIT_CYC);
      end
      if (stopOk) begin
         uart_rx = 1'b1;
         idle(BIT_CYC);
      end else begin
         uart_rx = 1'b0;
         idle(32);
         uart_rx = 1'b1;
         idle(BIT_CYC - 32);
      end
      idle(16);
   endtask

   task automatic pulseStart();
      start_load = 1'b1;
      idle(1);
      start_load = 1'b0;
      idle(1);
   endtask

   initial begin
      int base;
      logic [31:0] expWord;

      // Reset state
      idle(4);
      checkEq("rst_we", 32'(mem_we), 0);
      checkEq("rst_busy", 32'(load_busy), 0);
      rst = 1'b0;
      idle(2);
      checkEq("rst_addr", 32'(mem_addr), 0);
      checkEq("rst_wdata", mem_wdata, 0);
      checkEq("rst_done", 32'(load_done), 0);
      checkEq("rst_ferr", 32'(frame_err), 0);

      // Byte while IDLE is ignored
      sendByte(8'h55, 1'b1);
      checkEq("idle_nowrite", 32'(wrCount), 0);
      checkEq("idle_busy", 32'(load_busy), 0);

      // Full session: 32 bytes 0x00..0x1F
      pulseStart();
      checkEq("arm_busy", 32'(load_busy), 1);
      for (int i = 0; i < 32; i++) sendByte(8'(i), 1'b1);
      for (int t = 0; t < 500 && !load_done; t++) idle(1);
      checkEq("full_count", 32'(wrCount), 8);
      for (int w = 0; w < 8 && w < wrCount; w++) begin
         expWord = {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)};
         checkEq($sformatf("full_addr%0d", w), wrAddr[w], 32'(4*w));
         checkEq($sformatf("full_data%0d", w), wrData[w], expWord);
      end
      checkEq("full_done", 32'(load_done), 1);
      checkEq("full_busy", 32'(load_busy), 0);

      // Byte while DONE is ignored
      sendByte(8'h77, 1'b1);
      checkEq("done_nowrite", 32'(wrCount), 8);
      checkEq("done_hold", 32'(load_done), 1);

      // Short glitch inside a session: no byte
      pulseStart();
      checkEq("restart_done_clr", 32'(load_done), 0);
      base = wrCount;
      uart_rx = 1'b0;
      idle(14);
      uart_rx = 1'b1;
      idle(4 * BIT_CYC);
      checkEq("glitch_nowrite", 32'(wrCount), 32'(base));

      // Framing error then four good bytes
      sendByte(8'hA5, 1'b0);
      idle(2 * BIT_CYC);
      checkEq("ferr_set", 32'(frame_err), 1);
      checkEq("ferr_nowrite", 32'(wrCount), 32'(base));
      sendByte(8'h11, 1'b1);
      sendByte(8'h22, 1'b1);
      sendByte(8'h33, 1'b1);
      sendByte(8'h44, 1'b1);
      checkEq("ferr_count", 32'(wrCount), 32'(base + 1));
      if (wrCount == base + 1) begin
         checkEq("ferr_addr", wrAddr[base], 0);
         checkEq("ferr_data", wrData[base], 32'h44332211);
      end
      checkEq("ferr_sticky", 32'(frame_err), 1);

      // Six bytes, then restart: partial word discarded
      base = wrCount;
      for (int i = 0; i < 6; i++) sendByte(8'hA0 + 8'(i), 1'b1);
      checkEq("six_count", 32'(wrCount), 32'(base + 1));
      if (wrCount == base + 1) begin
         checkEq("six_addr", wrAddr[base], 4);
         checkEq("six_data", wrData[base], 32'hA3A2A1A0);
      end
      pulseStart();
      checkEq("restart_ferr_clr", 32'(frame_err), 0);
      base = wrCount;
      sendByte(8'h01, 1'b1);
      sendByte(8'h02, 1'b1);
      sendByte(8'h03, 1'b1);
      sendByte(8'h04, 1'b1);
      checkEq("restart_count", 32'(wrCount), 32'(base + 1));
      if (wrCount == base + 1) begin
         checkEq("restart_addr", wrAddr[base], 0);
         checkEq("restart_data", wrData[base], 32'h04030201);
      end

      // Reset mid-byte of word 2
      for (int i = 0; i < 4; i++) sendByte(8'hB0 + 8'(i), 1'b1);
      sendByte(8'hC0, 1'b1);
      sendByte(8'hC1, 1'b1);
      base = wrCount;
      uart_rx = 1'b0;
      idle(BIT_CYC);
      uart_rx = 1'b1;
      idle(3 * BIT_CYC);
      rst = 1'b1;
      idle(1);
      checkEq("midrst_we", 32'(mem_we), 0);
      checkEq("midrst_busy", 32'(load_busy), 0);
      checkEq("midrst_addr", 32'(mem_addr), 0);
      checkEq("midrst_wdata", mem_wdata, 0);
      rst = 1'b0;
      idle(12 * BIT_CYC);
      checkEq("midrst_nowrite", 32'(wrCount), 32'(base));
      pulseStart();
      sendByte(8'hDE, 1'b1);
      sendByte(8'hAD, 1'b1);
      sendByte(8'hBE, 1'b1);
      sendByte(8'hEF, 1'b1);
      checkEq("after_rst_count", 32'(wrCount), 32'(base + 1));
      if (wrCount == base + 1) begin
         checkEq("after_rst_addr", wrAddr[base], 0);
         checkEq("after_rst_data", wrData[base], 32'hEFBEADDE);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
      $finish;
   end

endmodule
